// File: rtl/in_to_fifo_pkg.sv
// Shared definitions for the ingress (producer -> byte FIFO) path and its drain-side twin.
// State encoding, default widths and 4-phase handshake levels live here.
package in_to_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Levels of the 4-phase start/finish handshake, as seen on either side of the FIFO.
    localparam logic HS_REQ_ON  = 1'b1;
    localparam logic HS_REQ_OFF = 1'b0;
    localparam logic HS_ACK_ON  = 1'b1;
    localparam logic HS_ACK_OFF = 1'b0;

    function automatic logic fifo_can_write(input logic busy, input logic full);
        return !busy && !full;
    endfunction

endpackage

// File: rtl/in_to_fifo_wrap_counter.sv
// Free-running modulo-2^CNT_W event counter with async active-high reset.
module in_to_fifo_wrap_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/in_to_fifo.sv
// Producer-to-FIFO ingress: 4-phase start/finish handshake, single-cycle FIFO write strobe.
// Define IN_TO_FIFO_DROP_ON_FULL_EN to discard (and count) bytes that meet a full FIFO.
module in_to_fifo
    import in_to_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_start,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_finish,
    input  logic              fifo_busy,
    input  logic              fifo_full,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              isFinish,
    output logic [CNT_W-1:0]  byte_count,
    output logic [CNT_W-1:0]  drop_count
);

    state_e            state_q,      state_d;
    logic              in_finish_q,  in_finish_d;
    logic              fifo_we_q,    fifo_we_d;
    logic              is_finish_q,  is_finish_d;
    logic [DATA_W-1:0] fifo_wdata_q, fifo_wdata_d;
    logic              byte_inc;
    logic              drop_inc;

    always_comb begin
        state_d      = state_q;
        in_finish_d  = in_finish_q;
        fifo_wdata_d = fifo_wdata_q;
        fifo_we_d    = 1'b0;
        is_finish_d  = 1'b0;
        byte_inc     = 1'b0;
        drop_inc     = 1'b0;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    in_finish_d = HS_ACK_OFF;
                    if (in_start == HS_REQ_ON) begin
                        fifo_wdata_d = in_data;
                        state_d      = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (fifo_can_write(fifo_busy, fifo_full)) begin
                        fifo_we_d = 1'b1;
                        byte_inc  = 1'b1;
                        state_d   = ST_ACK;
                    end
`ifdef IN_TO_FIFO_DROP_ON_FULL_EN
                    else if (!fifo_busy && fifo_full) begin
                        drop_inc = 1'b1;
                        state_d  = ST_ACK;
                    end
`endif
                end

                ST_ACK: begin
                    // First ACK cycle always raises in_finish, so a producer that
                    // already dropped in_start during WAIT still sees a one-cycle ack.
                    if (in_finish_q == HS_ACK_OFF) begin
                        in_finish_d = HS_ACK_ON;
                    end else if (in_start == HS_REQ_OFF) begin
                        in_finish_d = HS_ACK_OFF;
                        is_finish_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end

                default: begin
                    in_finish_d = HS_ACK_OFF;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_finish_q  <= 1'b0;
            fifo_we_q    <= 1'b0;
            is_finish_q  <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            in_finish_q  <= in_finish_d;
            fifo_we_q    <= fifo_we_d;
            is_finish_q  <= is_finish_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    in_to_fifo_wrap_counter #(
        .CNT_W (CNT_W)
    ) u_byte_counter (
        .clk   (clk),
        .rst   (reset),
        .inc   (byte_inc),
        .count (byte_count)
    );

    // Without the drop feature drop_inc never rises, so this count stays at zero.
    in_to_fifo_wrap_counter #(
        .CNT_W (CNT_W)
    ) u_drop_counter (
        .clk   (clk),
        .rst   (reset),
        .inc   (drop_inc),
        .count (drop_count)
    );

    assign in_finish  = in_finish_q;
    assign fifo_we    = fifo_we_q;
    assign isFinish   = is_finish_q;
    assign fifo_wdata = fifo_wdata_q;

endmodule

// File: tb/tb_in_to_fifo.sv
// Directed + randomized bench for in_to_fifo against a queue-based model of the byte stream.
module tb_in_to_fifo;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_start;
    logic [DATA_W-1:0] in_data;
    logic              in_finish;
    logic              fifo_busy;
    logic              fifo_full;
    logic              fifo_we;
    logic [DATA_W-1:0] fifo_wdata;
    logic              isFinish;
    logic [CNT_W-1:0]  byte_count;
    logic [CNT_W-1:0]  drop_count;

    in_to_fifo #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_start   (in_start),
        .in_data    (in_data),
        .in_finish  (in_finish),
        .fifo_busy  (fifo_busy),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .isFinish   (isFinish),
        .byte_count (byte_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the bytes the FIFO must receive, in order, and the transaction totals.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] wr_q[$];
    int exp_bytes = 0;
    int exp_fin   = 0;
    int fin_cnt   = 0;

    // Observed FIFO writes and completion pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && fifo_we) wr_q.push_back(fifo_wdata);
        if (!reset && isFinish) fin_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            check({tag, "_wdata"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    // Full 4-phase transaction; the first `stall` WAIT cycles see a not-ready FIFO.
    task automatic xfer(input logic [DATA_W-1:0] d, input int stall);
        int n;
        in_start = 1'b1;
        in_data  = d;
`ifdef IN_TO_FIFO_DROP_ON_FULL_EN
        fifo_busy = (stall > 0);
`else
        fifo_busy = (stall > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
        fifo_full = (stall > 0) ? !fifo_busy | 1'($urandom_range(0, 1)) : 1'b0;
        step();
        in_data = 8'($urandom);
        repeat (stall) step();
        fifo_busy = 1'b0;
        fifo_full = 1'b0;
        n = 0;
        while (!in_finish && n < 20) begin
            step();
            n++;
        end
        check("xfer_ack", 32'(in_finish), 32'd1);
        in_start = 1'b0;
        n = 0;
        while (!isFinish && n < 20) begin
            step();
            n++;
        end
        check("xfer_done", 32'(isFinish), 32'd1);
        step();
        exp_q.push_back(d);
        exp_bytes++;
        exp_fin++;
    endtask

    initial begin
        int bad_we;
        int bad_data;
        int bad_ack;

        reset     = 1'b1;
        enable    = 1'b1;
        in_start  = 1'b0;
        in_data   = '0;
        fifo_busy = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();

        check("rst_in_finish",  32'(in_finish),  32'd0);
        check("rst_fifo_we",    32'(fifo_we),    32'd0);
        check("rst_isfinish",   32'(isFinish),   32'd0);
        check("rst_wdata",      32'(fifo_wdata), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);

        // Reset while stalled in WAIT holding 8'hA5.
        in_start  = 1'b1;
        in_data   = 8'hA5;
        fifo_busy = 1'b1;
        step();
        step();
        check("midrst_held", 32'(fifo_wdata), 32'hA5);
        #3 reset = 1'b1;
        #1;
        check("midrst_wdata",      32'(fifo_wdata), 32'd0);
        check("midrst_fifo_we",    32'(fifo_we),    32'd0);
        check("midrst_in_finish",  32'(in_finish),  32'd0);
        check("midrst_byte_count", 32'(byte_count), 32'd0);
        in_start  = 1'b0;
        fifo_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("midrst_no_write", 32'(wr_q.size()), 32'd0);
        check("midrst_count",    32'(byte_count), 32'd0);

        // Single byte, FIFO ready: exact cycle-by-cycle latency.
        in_start = 1'b1;
        in_data  = 8'h3C;
        step();
        check("single_we_e0", 32'(fifo_we), 32'd0);
        in_data = 8'hFF;
        step();
        check("single_we_e1",    32'(fifo_we),    32'd1);
        check("single_wdata_e1", 32'(fifo_wdata), 32'h3C);
        check("single_fin_e1",   32'(in_finish),  32'd0);
        step();
        check("single_we_e2",  32'(fifo_we),   32'd0);
        check("single_fin_e2", 32'(in_finish), 32'd1);
        in_start = 1'b0;
        step();
        check("single_fin_e3", 32'(in_finish), 32'd0);
        check("single_isf_e3", 32'(isFinish),  32'd1);
        step();
        check("single_isf_e4", 32'(isFinish),   32'd0);
        check("single_count",  32'(byte_count), 32'd1);
        exp_q.push_back(8'h3C);
        exp_bytes++;
        exp_fin++;

        // Back-pressure: busy for 5 cycles, then full for 3, then ready.
        in_start  = 1'b1;
        in_data   = 8'h5A;
        fifo_busy = 1'b1;
        step();
        in_data  = 8'h00;
        bad_we   = 0;
        bad_data = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
`ifdef IN_TO_FIFO_DROP_ON_FULL_EN
                fifo_busy = 1'b1;
`else
                fifo_busy = 1'b0;
`endif
                fifo_full = 1'b1;
            end
            step();
            if (fifo_we) bad_we++;
            if (fifo_wdata !== 8'h5A) bad_data++;
        end
        check("bp_no_early_we", 32'(bad_we),   32'd0);
        check("bp_wdata_stable", 32'(bad_data), 32'd0);
        fifo_busy = 1'b0;
        fifo_full = 1'b0;
        step();
        check("bp_we",    32'(fifo_we),    32'd1);
        check("bp_wdata", 32'(fifo_wdata), 32'h5A);
        step();
        in_start = 1'b0;
        step();
        step();
        exp_q.push_back(8'h5A);
        exp_bytes++;
        exp_fin++;

        // Enable low while WAIT sees a ready FIFO.
        in_start  = 1'b1;
        in_data   = 8'hC3;
        fifo_busy = 1'b1;
        step();
        enable    = 1'b0;
        fifo_busy = 1'b0;
        bad_we    = 0;
        bad_ack   = 0;
        repeat (4) begin
            step();
            if (fifo_we) bad_we++;
            if (in_finish) bad_ack++;
        end
        check("en_no_we",  32'(bad_we),     32'd0);
        check("en_no_ack", 32'(bad_ack),    32'd0);
        check("en_frozen", 32'(byte_count), 32'd2);
        enable = 1'b1;
        step();
        check("en_we",    32'(fifo_we),    32'd1);
        check("en_wdata", 32'(fifo_wdata), 32'hC3);
        step();
        in_start = 1'b0;
        step();
        step();
        exp_q.push_back(8'hC3);
        exp_bytes++;
        exp_fin++;

        check("dir_count", 32'(byte_count), 32'(exp_bytes % 256));
        check_writes("dir");
        check("dir_fin", 32'(fin_cnt), 32'(exp_fin));

        // Counter wrap over 256 back-to-back bytes, starting from a clean reset.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        exp_bytes = 0;
        step();
        for (int i = 0; i < 256; i++) begin
            xfer(8'(i), 0);
            if (i == 254) check("wrap_count_ff", 32'(byte_count), 32'hFF);
        end
        check("wrap_count_zero", 32'(byte_count), 32'd0);
        check_writes("wrap");

        // Randomized data and stall lengths.
        for (int i = 0; i < 40; i++) begin
            xfer(8'($urandom), int'($urandom_range(0, 4)));
        end
        check("rand_count", 32'(byte_count), 32'(exp_bytes % 256));
        check_writes("rand");
        check("rand_fin", 32'(fin_cnt), 32'(exp_fin));

        // Full FIFO with busy clear: dropped when the feature is built in, stalled otherwise.
        in_start  = 1'b1;
        in_data   = 8'h77;
        fifo_full = 1'b1;
        step();
`ifdef IN_TO_FIFO_DROP_ON_FULL_EN
        step();
        check("drop_no_we", 32'(fifo_we), 32'd0);
        step();
        check("drop_ack",        32'(in_finish),  32'd1);
        check("drop_count_one",  32'(drop_count), 32'd1);
        check("drop_bytes_same", 32'(byte_count), 32'(exp_bytes % 256));
        in_start = 1'b0;
        step();
        check("drop_isf", 32'(isFinish), 32'd1);
        step();
        fifo_full = 1'b0;
        exp_fin++;
`else
        bad_we  = 0;
        bad_ack = 0;
        repeat (8) begin
            step();
            if (fifo_we) bad_we++;
            if (in_finish) bad_ack++;
        end
        check("full_no_we",     32'(bad_we),     32'd0);
        check("full_no_ack",    32'(bad_ack),    32'd0);
        check("full_drop_zero", 32'(drop_count), 32'd0);
        fifo_full = 1'b0;
        step();
        check("full_release_we", 32'(fifo_we), 32'd1);
        step();
        in_start = 1'b0;
        step();
        step();
        exp_q.push_back(8'h77);
        exp_bytes++;
        exp_fin++;
        check("full_count", 32'(byte_count), 32'(exp_bytes % 256));
`endif
        check_writes("full");
        check("final_fin", 32'(fin_cnt), 32'(exp_fin));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/in_to_fifo.md
Name: in_to_fifo

Overview:
- Ingress-side counterpart of the FIFO-to-output drain path.
- Accepts bytes from an upstream producer over a 4-phase start/finish handshake and writes each byte into the shared byte FIFO with a single-cycle write strobe.
- Respects the FIFO busy and full flags.
- Counts accepted bytes and reports per-byte completion to the controlling FSM.

Parameters:
- DATA_W, 8, width of the producer data and FIFO write data.
- CNT_W, 8, width of the byte and drop counters; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  block advances only while high.
- in_start  input  1  producer request; in_data is valid while high.
- in_data  input  DATA_W  producer byte.
- in_finish  output  1  acknowledge to producer.
- fifo_busy  input  1  FIFO is mid-operation; no write may be issued.
- fifo_full  input  1  FIFO has no free entry.
- fifo_we  output  1  one-cycle write strobe.
- fifo_wdata  output  DATA_W  byte being written.
- isFinish  output  1  one-cycle pulse when a byte transaction completes.
- byte_count  output  CNT_W  bytes written since reset.
- drop_count  output  CNT_W  bytes dropped (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - in_finish, fifo_we, isFinish, fifo_wdata, byte_count and drop_count all go to 0.
  - A transaction in flight is abandoned. No FIFO write is issued for it. The producer must re-raise in_start.
- enable low:
  - State and counters are frozen.
  - fifo_we and isFinish are forced to 0.
  - in_finish and fifo_wdata hold their values.
- IDLE:
  - in_finish=0.
  - If in_start=1, latch in_data into fifo_wdata and go to WAIT.
- WAIT:
  - If fifo_busy=0 and fifo_full=0: fifo_we=1 for this cycle, byte_count+1, go to ACK.
  - Otherwise stay (stall). fifo_wdata is held stable throughout.
- ACK:
  - fifo_we=0, in_finish=1.
  - When in_start=0: in_finish=0, isFinish=1 for one cycle, go to IDLE.
- Latency: in_start sampled at edge N with FIFO ready → fifo_we high after edge N+1 → in_finish high after edge N+2.
- Minimum handshake period is 4 cycles.
- in_data changes after the capture edge have no effect; the byte is latched once.
- in_start dropped while in WAIT: the byte is still written. ACK then completes immediately, with in_finish high for one cycle.
- byte_count wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous fifo_busy=0 and fifo_full toggling: the flags are sampled on the same edge as fifo_we is generated. No write is ever issued when fifo_full=1.
- Encoding: 2-bit state (IDLE=0, WAIT=1, ACK=2). The unused encoding 3 returns to IDLE.

Optional Feature:
- Macro: IN_TO_FIFO_DROP_ON_FULL_EN.
- Defined, in WAIT:
  - fifo_busy=0 and fifo_full=1: no write; drop_count+1; go to ACK. The producer is acknowledged normally and the byte is discarded.
  - fifo_busy=1 still stalls.
- Undefined:
  - A full FIFO stalls WAIT indefinitely.
  - drop_count is tied to 0.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE, WAIT, ACK).
  - Default DATA_W and CNT_W.
  - The handshake phase constants shared with the output-side drain block.
- One natural sub-module: wrap_counter (CNT_W-bit, increment enable, async active-high reset).
  - Instantiated twice, for byte_count and drop_count.

Test Plan:
- Reset mid-transaction: reset asserted while in WAIT with fifo_wdata=8'hA5 → all outputs 0 immediately; no fifo_we pulse; byte_count=0.
- Single byte, FIFO ready: in_start=1, in_data=8'h3C → fifo_we pulses exactly 1 cycle with fifo_wdata=8'h3C; in_finish rises 1 cycle later; dropping in_start gives isFinish=1 for 1 cycle; byte_count=1.
- Back-pressure: fifo_busy=1 for 5 cycles, then fifo_full=1 for 3 cycles, then both 0 → fifo_we only after both are clear; fifo_wdata stable throughout; exactly one write.
- Enable gating: enable=0 while in WAIT with FIFO ready for 4 cycles → no fifo_we; write occurs on the first enabled cycle.
- Counter wrap: 256 back-to-back bytes 8'h00..8'hFF → 256 writes in order; byte_count returns to 0.
- With IN_TO_FIFO_DROP_ON_FULL_EN: fifo_full=1, send 8'h77 → no fifo_we; in_finish asserted; drop_count=1; byte_count unchanged.
